// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types
// Description : Shared RV32 types for the EX stage: M-extension opcode enum,
//               M-extension sequencer state enum and the result-memo key.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    // M-extension funct3 encodings; bit 2 selects the divider family
    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_funct3_t;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2,
        S_DONE    = 2'd3
    } m_seq_state_t;

    // Memo key: an M-ext result is a pure function of these fields
    typedef struct packed {
        logic [2:0]  funct3;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } m_key_t;

    // True when the opcode belongs to the divider (div/divu/rem/remu)
    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_result_memo.sv
// ============================================================================
// Module      : m_result_memo
// Description : One-entry result memo for M-extension ops. Compares the
//               lookup key against the stored key and reports a hit; a write
//               replaces the single entry. Only reset invalidates it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_result_memo
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_lk_funct3,
    input  logic [31:0] i_lk_rs1,
    input  logic [31:0] i_lk_rs2,
    output logic        o_hit,
    output logic [31:0] o_hit_result,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_funct3,
    input  logic [31:0] i_wr_rs1,
    input  logic [31:0] i_wr_rs2,
    input  logic [31:0] i_wr_result
);

    logic        r_valid;
    m_key_t      r_key;
    logic [31:0] r_result;
    m_key_t      w_lk_key;

    assign w_lk_key     = '{funct3: i_lk_funct3, rs1: i_lk_rs1, rs2: i_lk_rs2};
    assign o_hit        = r_valid && (r_key == w_lk_key);
    assign o_hit_result = r_result;

    // Replace the single entry whenever a unit completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_key    <= '0;
            r_result <= '0;
        end else if (i_wr_en) begin
            r_valid  <= 1'b1;
            r_key    <= '{funct3: i_wr_funct3, rs1: i_wr_rs1, rs2: i_wr_rs2};
            r_result <= i_wr_result;
        end
    end

endmodule

`default_nettype wire

// File: rtl/m_ext_seq.sv
// ============================================================================
// Module      : m_ext_seq
// Description : EX-stage sequencer for RV32M. Issues one op to the external
//               multiplier or divider, holds operands stable while the unit
//               runs, stalls the pipeline, and holds the result until EX/MEM
//               accepts it. A one-entry memo short-circuits repeated ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_ext_seq
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic        flush,
    input  logic        out_ready,
    output logic        m_stall,
    output logic [31:0] m_result,
    output logic        m_result_valid,
    output logic [31:0] op_rs1,
    output logic [31:0] op_rs2,
    output logic [2:0]  op_funct3,
    output logic        is_mul,
    input  logic        mul_done,
    input  logic [31:0] mul_out,
    output logic        div_start,
    output logic        div_kill,
    input  logic        div_done,
    input  logic [31:0] div_out
);

    m_seq_state_t r_state;
    logic [31:0]  r_op_rs1;
    logic [31:0]  r_op_rs2;
    logic [2:0]   r_op_funct3;
    logic [31:0]  r_result;
    logic         r_result_valid;
    logic         r_is_mul;
    logic         r_div_start;
    logic         r_div_kill;

    logic         w_hit;
    logic [31:0]  w_hit_result;
    logic         w_memo_wr;
    logic [31:0]  w_memo_wdata;

    // The memo learns every completion, even one that coincides with a flush,
    // because the result depends only on the operands.
    assign w_memo_wr    = ((r_state == S_MUL_RUN) && mul_done) ||
                          ((r_state == S_DIV_RUN) && div_done);
    assign w_memo_wdata = (r_state == S_MUL_RUN) ? mul_out : div_out;

    m_result_memo u_memo (
        .clk          (clk),
        .rst          (rst),
        .i_lk_funct3  (ex_funct3),
        .i_lk_rs1     (ex_rs1),
        .i_lk_rs2     (ex_rs2),
        .o_hit        (w_hit),
        .o_hit_result (w_hit_result),
        .i_wr_en      (w_memo_wr),
        .i_wr_funct3  (r_op_funct3),
        .i_wr_rs1     (r_op_rs1),
        .i_wr_rs2     (r_op_rs2),
        .i_wr_result  (w_memo_wdata)
    );

    // Sequencer FSM with registered unit controls and result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_op_rs1       <= '0;
            r_op_rs2       <= '0;
            r_op_funct3    <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_is_mul       <= 1'b0;
            r_div_start    <= 1'b0;
            r_div_kill     <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            r_div_kill  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid && !flush) begin
                        // Operands are frozen here until the state returns to IDLE
                        r_op_rs1    <= ex_rs1;
                        r_op_rs2    <= ex_rs2;
                        r_op_funct3 <= ex_funct3;
                        if (w_hit) begin
                            r_result       <= w_hit_result;
                            r_result_valid <= 1'b1;
                            r_state        <= S_DONE;
                        end else if (is_div_op(ex_funct3)) begin
                            r_div_start <= 1'b1;
                            r_state     <= S_DIV_RUN;
                        end else begin
                            r_is_mul <= 1'b1;
                            r_state  <= S_MUL_RUN;
                        end
                    end
                end
                S_MUL_RUN: begin
                    // Dropping is_mul also clears the multiplier's cycle counter
                    if (flush) begin
                        r_is_mul <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (mul_done) begin
                        r_is_mul       <= 1'b0;
                        r_result       <= mul_out;
                        r_result_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DIV_RUN: begin
                    if (flush) begin
                        r_div_kill <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (div_done) begin
                        r_result       <= div_out;
                        r_result_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        r_result_valid <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign op_rs1         = r_op_rs1;
    assign op_rs2         = r_op_rs2;
    assign op_funct3      = r_op_funct3;
    assign is_mul         = r_is_mul;
    assign div_start      = r_div_start;
    assign div_kill       = r_div_kill;
    assign m_result       = r_result;
    assign m_result_valid = r_result_valid;
    assign m_stall        = ex_valid & ~(r_result_valid & out_ready);

endmodule

`default_nettype wire

// File: doc/m_ext_seq.md
# m_ext_seq

Sequencer for RV32M instructions in the EX stage. Accepts one M-extension op from the ID/EX register, holds operands stable for the multi-cycle multiplier (funct3 0–3) or the iterative divider (funct3 4–7), and stalls the pipeline while the unit runs. Captures and holds the result until the EX/MEM register accepts it. Keeps a one-entry result memo so an identical repeated op completes in one cycle.

## Interface
Parameters: none. Enum widths are fixed by `rv32i_types`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  EX holds a valid M-ext instruction
- `ex_funct3`  in  3  `m_funct3_t` opcode
- `ex_rs1`, `ex_rs2`  in  32  forwarded operand values
- `flush`  in  1  kill the instruction in EX (branch/trap)
- `out_ready`  in  1  EX/MEM register can accept a result this cycle
- `m_stall`  out  1  hold IF/ID/EX
- `m_result`  out  32  result to EX/MEM
- `m_result_valid`  out  1  `m_result` is valid
- `op_rs1`, `op_rs2`  out  32  registered operands to multiplier and divider
- `op_funct3`  out  3  registered funct3 to both units
- `is_mul`  out  1  multiplier run level
- `mul_done`  in  1  one-cycle completion pulse
- `mul_out`  in  32  valid when `mul_done`=1
- `div_start`  out  1  one-cycle start pulse
- `div_kill`  out  1  one-cycle abort pulse
- `div_done`  in  1  one-cycle completion pulse
- `div_out`  in  32  valid when `div_done`=1

## Operation
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE, `ex_valid`=1, `flush`=0:
  - Always latch `ex_rs1`/`ex_rs2`/`ex_funct3` into the op registers.
  - Memo hit (valid, same funct3, same rs1, same rs2): load memo value into the result register, go to DONE.
  - Miss with funct3[2]=0: go to MUL_RUN.
  - Miss with funct3[2]=1: go to DIV_RUN; assert `div_start` in the first DIV_RUN cycle only.
- MUL_RUN: `is_mul`=1 in every cycle of the state. On `mul_done`, capture `mul_out`, update the memo, go to DONE. `is_mul` is 0 from the cycle after `mul_done`, which clears the multiplier's cycle counter.
- DIV_RUN: on `div_done`, capture `div_out`, update the memo, go to DONE.
- DONE: `m_result_valid`=1. When `out_ready`=1 the result is consumed; go to IDLE. When `out_ready`=0, hold the result unchanged.
- `m_stall` = `ex_valid` & ~(`m_result_valid` & `out_ready`).
- Operands are held stable for the whole run. The multiplier samples them one cycle late internally, so `op_*` must not change until the state returns to IDLE.
- Memo: one entry {valid, funct3, rs1, rs2, result}. It is a pure function of its key and is never invalidated except by reset.
- `flush` in MUL_RUN: drop `is_mul`, go to IDLE, discard the result.
- `flush` in DIV_RUN: pulse `div_kill`, go to IDLE.
- `flush` in DONE: drop the result, go to IDLE.
- `flush` in IDLE: no issue.
- `flush` in the same cycle as `mul_done`/`div_done`: the memo is still updated; the state goes to IDLE; no result is presented.

## Timing
- Reset values: state IDLE; memo invalid; `op_*`=0; all outputs 0.
- Issue is in cycle t (IDLE, `ex_valid`).
  - Memo hit: `m_result_valid` at t+1 (one stall cycle).
  - MUL: `is_mul` high from t+1; result valid in the cycle after `mul_done`.
  - With the current multiplier: `mul` result at t+4; `mulh`/`mulhsu`/`mulhu` at t+5.
  - DIV: `div_start` at t+1; result valid in the cycle after `div_done`.
- The sequencer tolerates `mul_done` and `div_done` at any cycle count ≥1 after start. Completion pulses in the wrong state are ignored.
- Back-to-back ops: after a DONE handshake, IDLE evaluates the next `ex_valid` in the following cycle. Throughput is one op per (latency+1) cycles on a miss.
- Reset asserted mid-operation: immediate return to reset values; `is_mul` falls asynchronously.

## Structure
- `rv32i_types` gains `m_seq_state_t` (IDLE, MUL_RUN, DIV_RUN, DONE).
- It reuses `m_funct3_t` (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
- One sub-module, `m_result_memo`: key compare, hit output, write port. Clocked on `clk`/`rst`.
- The multiplier and divider are instantiated by the EX stage beside this block, not inside it.

## Test plan
- `mul` 7 × 0xFFFFFFFD → `is_mul` high t+1..t+3, `m_result`=0xFFFFFFEB valid at t+4, `m_stall` low once `out_ready`=1.
- `mulh` 0x80000000 × 0x80000000 → 0x40000000. `mulhu` 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. `mulhsu` 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Repeat `mulhu` 0xFFFFFFFF × 0xFFFFFFFF → memo hit: 0xFFFFFFFE valid at t+1, `is_mul` never asserted.
- `div` with a stub divider (`div_done` after 33 cycles) → single `div_start` pulse, result held 3 cycles while `out_ready`=0, accepted when 1.
- `flush` at t+2 of a `mul` → `is_mul` low at t+3, no `m_result_valid`. Next `mul` completes normally with the correct value.
- `rst` low during MUL_RUN → all outputs 0 immediately. After release the memo misses on a previously cached op.
